// File: rtl/os_scheduler.sv
// Ordered-set scheduler: brings a link from DOWN through an IDLE training run into RUN.
// Define OS_SCHEDULER_CC_EN to insert periodic clock-compensation (CC) bursts.
module os_scheduler #(
    parameter int AXI_DATA_SIZE  = 32,
    parameter int MAX_LINKS_SIZE = 4,
    parameter int DATA_W         = AXI_DATA_SIZE,
    parameter int INIT_IDLES     = 64,
    parameter int CC_PERIOD      = 5000,
    parameter int CC_LEN         = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      link_up,
    input  logic                      single_lane_cfg,
    input  logic [MAX_LINKS_SIZE-1:0] lane_select_cfg,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic                      single_lane,
    output logic [MAX_LINKS_SIZE-1:0] lane_select,
    output logic [1:0]                os_code,
    output logic [DATA_W-1:0]         data_out,
    output logic                      channel_up,
    output logic [1:0]                state_dbg
);

    localparam logic [1:0] OS_NONE = 2'd0;
    localparam logic [1:0] OS_IDLE = 2'd1;
    localparam logic [1:0] OS_CC   = 2'd2;
    localparam logic [1:0] OS_DATA = 2'd3;

    localparam int              IW        = (INIT_IDLES > 1) ? $clog2(INIT_IDLES + 1) : 1;
    localparam logic [IW-1:0]   INIT_LAST = IW'(INIT_IDLES - 1);

`ifdef OS_SCHEDULER_CC_EN
    localparam int              CW         = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    localparam logic [CW-1:0]   CC_LAST    = CW'(CC_PERIOD - 1);
    localparam int              BW         = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
    localparam logic [BW-1:0]   BURST_LAST = BW'(CC_LEN - 1);
`endif

    typedef enum logic [1:0] {
        S_DOWN = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
`ifdef OS_SCHEDULER_CC_EN
        ,S_CC  = 2'd3
`endif
    } state_t;

    state_t        state, next_state;
    logic [IW-1:0] init_cnt;
    logic          cfg_diff;
    logic          xfer;
    logic [1:0]    os_code_nxt;
`ifdef OS_SCHEDULER_CC_EN
    logic [CW-1:0] cc_cnt;
    logic [BW-1:0] burst_cnt;
`endif

    assign state_dbg = state;
    assign cfg_diff  = (single_lane_cfg != single_lane) || (lane_select_cfg != lane_select);
    assign xfer      = s_axis_tready & s_axis_tvalid;

    // Handshake: a word moves only in a cycle where tvalid and tready are both high;
    // tready is also withheld on a config change so no accepted word is ever dropped.
    always_comb begin
        next_state    = state;
        s_axis_tready = 1'b0;
        case (state)
            S_DOWN: if (link_up) next_state = S_INIT;
            S_INIT: begin
                if (!link_up)                  next_state = S_DOWN;
                else if (init_cnt == INIT_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                if (!link_up)       next_state = S_DOWN;
                else if (cfg_diff)  next_state = S_INIT;
`ifdef OS_SCHEDULER_CC_EN
                else if (cc_cnt == CC_LAST) next_state = S_CC;
`endif
                else                s_axis_tready = 1'b1;
            end
`ifdef OS_SCHEDULER_CC_EN
            S_CC: begin
                if (!link_up)                   next_state = S_DOWN;
                else if (cfg_diff)              next_state = S_INIT;
                else if (burst_cnt == BURST_LAST) next_state = S_RUN;
            end
`endif
            default: next_state = S_DOWN;
        endcase
    end

    always_comb begin
        os_code_nxt = OS_NONE;
        case (next_state)
            S_INIT:  os_code_nxt = OS_IDLE;
            S_RUN:   os_code_nxt = xfer ? OS_DATA : OS_IDLE;
`ifdef OS_SCHEDULER_CC_EN
            S_CC:    os_code_nxt = OS_CC;
`endif
            default: os_code_nxt = OS_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_DOWN;
            init_cnt    <= '0;
            os_code     <= OS_NONE;
            data_out    <= '0;
            channel_up  <= 1'b0;
            single_lane <= 1'b0;
            lane_select <= '0;
        end else begin
            state      <= next_state;
            os_code    <= os_code_nxt;
            channel_up <= (next_state == S_RUN)
`ifdef OS_SCHEDULER_CC_EN
                          || (next_state == S_CC)
`endif
                          ;
            init_cnt   <= (state == S_INIT && next_state == S_INIT) ? init_cnt + 1'b1 : '0;
            if (xfer) data_out <= s_axis_tdata;
            // Lane configuration is sampled only as INIT is entered, so a retrain always uses it.
            if (next_state == S_INIT && state != S_INIT) begin
                single_lane <= single_lane_cfg;
                lane_select <= lane_select_cfg;
            end
        end
    end

`ifdef OS_SCHEDULER_CC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_cnt    <= '0;
            burst_cnt <= '0;
        end else begin
            cc_cnt    <= (state == S_RUN && next_state == S_RUN) ? cc_cnt + 1'b1 : '0;
            burst_cnt <= (state == S_CC && next_state == S_CC) ? burst_cnt + 1'b1 : '0;
        end
    end
`endif

endmodule

// File: tb/tb_os_scheduler.sv
// Directed table-driven bench for os_scheduler (INIT_IDLES=4, CC_PERIOD=16, CC_LEN=3).
// Covers whichever build OS_SCHEDULER_CC_EN selects.
module tb_os_scheduler;

    localparam int DW = 32;
    localparam int LW = 4;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_IDLE = 2'd1;
    localparam logic [1:0] C_CC   = 2'd2;
    localparam logic [1:0] C_DATA = 2'd3;
    localparam logic [1:0] S_DOWN = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_CC   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_up;
    logic          single_lane_cfg;
    logic [LW-1:0] lane_select_cfg;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          single_lane;
    logic [LW-1:0] lane_select;
    logic [1:0]    os_code;
    logic [DW-1:0] data_out;
    logic          channel_up;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          link;
        logic          slc;
        logic [LW-1:0] lsc;
        logic          vld;
        logic [DW-1:0] dat;
        logic          chk_rdy;
        logic          rdy;
        logic [1:0]    code;
        logic [DW-1:0] dout;
        logic          chup;
        logic          sl;
        logic [LW-1:0] ls;
        logic [1:0]    st;
    } vec_t;

    vec_t vecs[$];

    os_scheduler #(
        .AXI_DATA_SIZE(DW), .MAX_LINKS_SIZE(LW), .DATA_W(DW),
        .INIT_IDLES(4), .CC_PERIOD(16), .CC_LEN(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link_up(link_up),
        .single_lane_cfg(single_lane_cfg), .lane_select_cfg(lane_select_cfg),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .single_lane(single_lane),
        .lane_select(lane_select), .os_code(os_code), .data_out(data_out),
        .channel_up(channel_up), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t row(input logic link, input logic slc, input logic [LW-1:0] lsc,
                                 input logic vld, input logic [DW-1:0] dat, input logic chk_rdy,
                                 input logic rdy, input logic [1:0] code, input logic [DW-1:0] dout,
                                 input logic chup, input logic sl, input logic [LW-1:0] ls,
                                 input logic [1:0] st);
        vec_t v;
        v.link = link; v.slc = slc; v.lsc = lsc; v.vld = vld; v.dat = dat;
        v.chk_rdy = chk_rdy; v.rdy = rdy; v.code = code; v.dout = dout;
        v.chup = chup; v.sl = sl; v.ls = ls; v.st = st;
        return v;
    endfunction

    // Called just after a rising edge: drive, check tready, then check registered outputs.
    task automatic apply_vec(input vec_t v, input int idx);
        logic [DW-1:0] w;
        link_up = v.link; single_lane_cfg = v.slc; lane_select_cfg = v.lsc;
        s_axis_tvalid = v.vld; s_axis_tdata = v.dat;
        #1;
        if (v.chk_rdy) check("tready", idx, {31'd0, s_axis_tready}, {31'd0, v.rdy});
        if (v.vld && v.chk_rdy && v.rdy) exp_q.push_back(v.dat);
        @(posedge clk);
        #1;
        check("os_code", idx, {30'd0, os_code}, {30'd0, v.code});
        check("data_out", idx, data_out, v.dout);
        check("channel_up", idx, {31'd0, channel_up}, {31'd0, v.chup});
        check("single_lane", idx, {31'd0, single_lane}, {31'd0, v.sl});
        check("lane_select", idx, {28'd0, lane_select}, {28'd0, v.ls});
        check("state", idx, {30'd0, state_dbg}, {30'd0, v.st});
        if (os_code == C_DATA) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_data step %0d: got %0h expected no word", idx, data_out);
            end else begin
                w = exp_q.pop_front();
                check("sb_word", idx, data_out, w);
            end
        end
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_os_code", idx, {30'd0, os_code}, {30'd0, C_NONE});
        check("rst_data_out", idx, data_out, '0);
        check("rst_channel_up", idx, {31'd0, channel_up}, 32'd0);
        check("rst_single_lane", idx, {31'd0, single_lane}, 32'd0);
        check("rst_lane_select", idx, {28'd0, lane_select}, 32'd0);
        check("rst_state", idx, {30'd0, state_dbg}, {30'd0, S_DOWN});
    endtask

    initial begin
        logic [DW-1:0] w;
        // Startup: one DOWN cycle, four IDLEs, then RUN.
        for (int i = 0; i < 4; i++) vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_IDLE, 0, 0, 0, 0, S_INIT));
        vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_IDLE, 0, 1, 0, 0, S_RUN));
`ifdef OS_SCHEDULER_CC_EN
        // Continuous stream across a CC burst: 15 words, 3 CC, one IDLE, then 0x10.
        w = 1;
        for (int i = 0; i < 20; i++) begin
            if (i <= 14 || i == 19) begin
                vecs.push_back(row(1, 0, 0, 1, w, 1, 1, C_DATA, w, 1, 0, 0, S_RUN));
                w++;
            end else if (i <= 17) begin
                vecs.push_back(row(1, 0, 0, 1, w, 1, 0, C_CC, 32'hF, 1, 0, 0, S_CC));
            end else begin
                vecs.push_back(row(1, 0, 0, 1, w, 1, 0, C_IDLE, 32'hF, 1, 0, 0, S_RUN));
            end
        end
`else
        for (int i = 0; i < 40; i++)
            vecs.push_back(row(1, 0, 0, 1, i + 1, 1, 1, C_DATA, i + 1, 1, 0, 0, S_RUN));
`endif
        // Alternating tvalid: DATA/IDLE with data_out holding.
        vecs.push_back(row(1, 0, 0, 1, 32'h21, 1, 1, C_DATA, 32'h21, 1, 0, 0, S_RUN));
        vecs.push_back(row(1, 0, 0, 0, 32'h99, 1, 1, C_IDLE, 32'h21, 1, 0, 0, S_RUN));
        vecs.push_back(row(1, 0, 0, 1, 32'h22, 1, 1, C_DATA, 32'h22, 1, 0, 0, S_RUN));
        vecs.push_back(row(1, 0, 0, 0, 32'h98, 1, 1, C_IDLE, 32'h22, 1, 0, 0, S_RUN));
`ifdef OS_SCHEDULER_CC_EN
        // Idle through to the next CC burst, drop link in its second cycle.
        for (int i = 0; i < 10; i++) vecs.push_back(row(1, 0, 0, 0, 0, 1, 1, C_IDLE, 32'h22, 1, 0, 0, S_RUN));
        vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_CC, 32'h22, 1, 0, 0, S_CC));
        vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_CC, 32'h22, 1, 0, 0, S_CC));
        vecs.push_back(row(0, 0, 0, 1, 32'h77, 1, 0, C_NONE, 32'h22, 0, 0, 0, S_DOWN));
`else
        vecs.push_back(row(0, 0, 0, 1, 32'h77, 1, 0, C_NONE, 32'h22, 0, 0, 0, S_DOWN));
`endif
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, C_NONE, 32'h22, 0, 0, 0, S_DOWN));
        // Link returns: full 4-IDLE training again.
        for (int i = 0; i < 4; i++) vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_IDLE, 32'h22, 0, 0, 0, S_INIT));
        vecs.push_back(row(1, 0, 0, 0, 0, 1, 0, C_IDLE, 32'h22, 1, 0, 0, S_RUN));
        // Config change in RUN: re-latch and retrain.
        vecs.push_back(row(1, 1, 2, 0, 0, 0, 0, C_IDLE, 32'h22, 0, 1, 2, S_INIT));
        for (int i = 0; i < 3; i++) vecs.push_back(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 32'h22, 0, 1, 2, S_INIT));
        vecs.push_back(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 32'h22, 1, 1, 2, S_RUN));
        vecs.push_back(row(1, 1, 2, 1, 32'h55, 1, 1, C_DATA, 32'h55, 1, 1, 2, S_RUN));
        vecs.push_back(row(0, 1, 2, 0, 0, 1, 0, C_NONE, 32'h55, 0, 1, 2, S_DOWN));
        vecs.push_back(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 32'h55, 0, 1, 2, S_INIT));
        vecs.push_back(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 32'h55, 0, 1, 2, S_INIT));

        rst_n = 1'b0; link_up = 1'b0; single_lane_cfg = 1'b0; lane_select_cfg = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        #2;
        check_reset_state(-1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_reset_state(-2);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Asynchronous reset in the middle of INIT: everything clears at once,
        // then training restarts with a full IDLE count.
        rst_n = 1'b0;
        #1;
        check_reset_state(-3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            apply_vec(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 0, 0, 1, 2, S_INIT), 1000 + i);
        apply_vec(row(1, 1, 2, 0, 0, 1, 0, C_IDLE, 0, 1, 1, 2, S_RUN), 1004);
        apply_vec(row(1, 1, 2, 1, 32'hA5, 1, 1, C_DATA, 32'hA5, 1, 1, 2, S_RUN), 1005);

        check("sb_leftover", 0, exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/os_scheduler.md
OS_SCHEDULER -- requirements
Module: os_scheduler

Interface
REQ-001 Parameter DATA_W, default AXI_DATA_SIZE, lane-controller data width.
REQ-002 Parameter INIT_IDLES, default 64, IDLE cycles sent after link_up before channel_up.
REQ-003 Parameter CC_PERIOD, default 5000, cycles between clock-compensation bursts (>= 4).
REQ-004 Parameter CC_LEN, default 3, cycles per clock-compensation burst (>= 1).
REQ-005 clk  in  1  sole clock, lane_controller clock domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 link_up  in  1  all selected lanes aligned.
REQ-008 single_lane_cfg  in  1  requested single-lane mode.
REQ-009 lane_select_cfg  in  MAX_LINKS_SIZE  requested lane in single-lane mode.
REQ-010 s_axis_tdata  in  DATA_W  user data.
REQ-011 s_axis_tvalid  in  1  user data valid.
REQ-012 s_axis_tready  out  1  scheduler accepts data; combinational.
REQ-013 single_lane  out  1  latched mode to lane_controller.
REQ-014 lane_select  out  MAX_LINKS_SIZE  latched lane to lane_controller.
REQ-015 os_code  out  2  0 NONE, 1 IDLE, 2 CC, 3 DATA; registered.
REQ-016 data_out  out  DATA_W  data to lane_controller; registered.
REQ-017 channel_up  out  1  high in RUN and CC states; registered.

Function
REQ-018 FSM states DOWN, INIT, RUN, CC; single transition per clk edge.
REQ-019 DOWN: os_code=NONE; go to INIT when link_up=1.
REQ-020 On entry to INIT, single_lane/lane_select latch single_lane_cfg/lane_select_cfg; hold otherwise.
REQ-021 INIT: os_code=IDLE; counter runs INIT_IDLES cycles, then RUN with cc_cnt=0.
REQ-022 RUN: s_axis_tready=1 except when cc_cnt==CC_PERIOD-1.
REQ-023 RUN, tvalid&tready: next cycle os_code=DATA, data_out=tdata (latency 1).
REQ-024 RUN, no transfer: next cycle os_code=IDLE, data_out holds previous value.
REQ-025 RUN: cc_cnt increments per cycle; at CC_PERIOD-1 tready=0 and next state CC.
REQ-026 CC: os_code=CC for exactly CC_LEN cycles, tready=0, then RUN with cc_cnt=0.
REQ-027 link_up=0 in INIT, RUN or CC: next state DOWN, tready=0 same cycle, os_code=NONE next cycle.
REQ-028 cfg inputs differing from latched values in RUN or CC: next state INIT (re-latch), takes priority over CC entry; link_up=0 takes priority over both.
REQ-029 tready is 0 in DOWN, INIT, CC; no data accepted or dropped while tready=0.
REQ-030 Counters saturate-free: cc_cnt width clog2(CC_PERIOD), init counter width clog2(INIT_IDLES+1).

Reset
REQ-031 rst_n=0 asynchronously: state DOWN, os_code=NONE, data_out=0, channel_up=0, single_lane=0, lane_select=0, all counters 0.
REQ-032 Reset deassertion mid-burst or mid-INIT restarts from DOWN; no partial CC or IDLE count retained.

Configuration
REQ-033 Macro OS_SCHEDULER_CC_EN defined: CC state and cc_cnt present per REQ-025/026.
REQ-034 OS_SCHEDULER_CC_EN undefined: CC state and cc_cnt removed, tready=1 throughout RUN, os_code never CC.

Verification (INIT_IDLES=4, CC_PERIOD=16, CC_LEN=3, CC enabled)
REQ-035 rst_n pulse low, link_up=1 at t0 -> os_code NONE, then IDLE 4 cycles, channel_up=1 on 5th cycle after INIT entry.
REQ-036 tvalid=1 continuous, tdata incrementing from 0x1 -> 15 DATA words 0x1..0xF, 3 CC cycles, then 0x10 next; no word lost or repeated.
REQ-037 tvalid toggling 1/0 in RUN -> os_code alternates DATA/IDLE, data_out holds last word during IDLE.
REQ-038 link_up dropped during 2nd CC cycle -> tready=0, os_code=NONE next cycle, full INIT (4 IDLEs) after link_up returns.
REQ-039 single_lane_cfg 0->1, lane_select_cfg=2 in RUN -> INIT re-entered, single_lane=1, lane_select=2, channel_up=0 for 4 cycles.
REQ-040 CC disabled build, 40 cycles tvalid=1 -> 40 consecutive DATA, os_code never 2.
